// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue/collect stage: RV32I opcodes, the 5-bit
// ALU op encoding and the controller FSM state type.
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU op = {is_branch, f7[5], f3}
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_BEQ  = 5'b10000;
    localparam logic [4:0] ALU_BNE  = 5'b10001;
    localparam logic [4:0] ALU_BLT  = 5'b10100;
    localparam logic [4:0] ALU_BGE  = 5'b10101;
    localparam logic [4:0] ALU_BLTU = 5'b10110;
    localparam logic [4:0] ALU_BGEU = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CAPT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of one instruction into ALU op, operands, destination,
// branch flag, decode fault and branch target.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] pc,
    output logic [4:0]  op,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [4:0]  rd,
    output logic        is_branch,
    output logic        fault,
    output logic [31:0] target
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic        unused_rs1_field;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign target = pc + imm_b;

    // Register numbers arrive already resolved as rs1/rs2 values.
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        op        = ALU_ADD;
        a         = '0;
        b         = '0;
        rd        = instr[11:7];
        is_branch = 1'b0;
        fault     = 1'b0;
        case (opcode)
            OPC_OP: begin
                op    = {1'b0, f7[5], f3};
                a     = rs1;
                b     = rs2;
                fault = (f7 != F7_BASE) && (f7 != F7_ALT);
            end
            OPC_OP_IMM: begin
                a = rs1;
                b = imm_i;
                if (f3 == 3'b101) begin
                    op    = {1'b0, f7[5], f3};
                    fault = (f7 != F7_BASE) && (f7 != F7_ALT);
                end else begin
                    op    = {2'b00, f3};
                    fault = (f3 == 3'b001) && (f7 != F7_BASE);
                end
            end
            OPC_BRANCH: begin
                op        = {2'b10, f3};
                a         = rs1;
                b         = rs2;
                rd        = '0;
                is_branch = 1'b1;
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// Issue/collect stage around the one-cycle ALU: accept, drive registered ALU
// inputs, capture the result and hold it for the writeback/PC stage.
module alu_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_pc,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_fault,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic        out_wb_en,
    output logic [31:0] out_value,
    output logic        out_br_taken,
    output logic [31:0] out_br_target,
    output logic        out_fault
);

    logic [4:0]  dec_op;
    logic [31:0] dec_a, dec_b, dec_target;
    logic [4:0]  dec_rd;
    logic        dec_branch, dec_fault;

    alu_decode u_decode (
        .instr     (in_instr),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .pc        (in_pc),
        .op        (dec_op),
        .a         (dec_a),
        .b         (dec_b),
        .rd        (dec_rd),
        .is_branch (dec_branch),
        .fault     (dec_fault),
        .target    (dec_target)
    );

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [4:0]  rd_q, rd_d;
    logic        branch_q, branch_d;
    logic        dec_fault_q, dec_fault_d;
    logic [31:0] target_q, target_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_wb_en_q, out_wb_en_d;
    logic [31:0] out_value_q, out_value_d;
    logic        out_br_taken_q, out_br_taken_d;
    logic [31:0] out_br_target_q, out_br_target_d;
    logic        out_fault_q, out_fault_d;
    logic        capt_fault;

    always_comb begin
        state_d         = state_q;
        in_ready_d      = in_ready_q;
        alu_op_d        = alu_op_q;
        alu_a_d         = alu_a_q;
        alu_b_d         = alu_b_q;
        rd_d            = rd_q;
        branch_d        = branch_q;
        dec_fault_d     = dec_fault_q;
        target_d        = target_q;
        out_valid_d     = out_valid_q;
        out_rd_d        = out_rd_q;
        out_wb_en_d     = out_wb_en_q;
        out_value_d     = out_value_q;
        out_br_taken_d  = out_br_taken_q;
        out_br_target_d = out_br_target_q;
        out_fault_d     = out_fault_q;
        capt_fault      = alu_fault | dec_fault_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d     = ST_EXEC;
                    in_ready_d  = 1'b0;
                    alu_op_d    = dec_op;
                    alu_a_d     = dec_a;
                    alu_b_d     = dec_b;
                    rd_d        = dec_rd;
                    branch_d    = dec_branch;
                    dec_fault_d = dec_fault;
                    target_d    = dec_target;
                end
            end
            ST_EXEC: state_d = ST_CAPT;
            ST_CAPT: begin
                // The ALU result for the held inputs is valid during this cycle.
                state_d         = ST_RESP;
                out_valid_d     = 1'b1;
                out_value_d     = alu_out;
                out_fault_d     = capt_fault;
                out_rd_d        = rd_q;
                out_wb_en_d     = ~branch_q & ~capt_fault & (rd_q != 5'd0);
                out_br_taken_d  = branch_q & alu_out[0] & ~capt_fault;
                out_br_target_d = target_q;
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            in_ready_q      <= 1'b1;
            alu_op_q        <= '0;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            rd_q            <= '0;
            branch_q        <= 1'b0;
            dec_fault_q     <= 1'b0;
            target_q        <= '0;
            out_valid_q     <= 1'b0;
            out_rd_q        <= '0;
            out_wb_en_q     <= 1'b0;
            out_value_q     <= '0;
            out_br_taken_q  <= 1'b0;
            out_br_target_q <= '0;
            out_fault_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop sees pre-edge values.
            state_q         <= state_d;
            in_ready_q      <= in_ready_d;
            alu_op_q        <= alu_op_d;
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            rd_q            <= rd_d;
            branch_q        <= branch_d;
            dec_fault_q     <= dec_fault_d;
            target_q        <= target_d;
            out_valid_q     <= out_valid_d;
            out_rd_q        <= out_rd_d;
            out_wb_en_q     <= out_wb_en_d;
            out_value_q     <= out_value_d;
            out_br_taken_q  <= out_br_taken_d;
            out_br_target_q <= out_br_target_d;
            out_fault_q     <= out_fault_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign alu_op        = alu_op_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign out_valid     = out_valid_q;
    assign out_rd        = out_rd_q;
    assign out_wb_en     = out_wb_en_q;
    assign out_value     = out_value_q;
    assign out_br_taken  = out_br_taken_q;
    assign out_br_target = out_br_target_q;
    assign out_fault     = out_fault_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: a behavioural one-cycle ALU, a vector table
// with a scoreboard queue, plus backpressure and mid-flight reset sequences.
module tb_alu_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0, in_rs1 = '0, in_rs2 = '0, in_pc = '0;
    logic [4:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_out;
    logic        alu_fault;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic [31:0] out_value;
    logic        out_br_taken;
    logic [31:0] out_br_target;
    logic        out_fault;

    alu_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_pc         (in_pc),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_out       (alu_out),
        .alu_fault     (alu_fault),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rd        (out_rd),
        .out_wb_en     (out_wb_en),
        .out_value     (out_value),
        .out_br_taken  (out_br_taken),
        .out_br_target (out_br_target),
        .out_fault     (out_fault)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: registers its result one cycle after sampling inputs.
    function automatic logic [32:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return {1'b0, a + b};
            ALU_SUB:  return {1'b0, a - b};
            ALU_SLL:  return {1'b0, a << b[4:0]};
            ALU_SLT:  return {1'b0, 31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {1'b0, 31'd0, a < b};
            ALU_XOR:  return {1'b0, a ^ b};
            ALU_SRL:  return {1'b0, a >> b[4:0]};
            ALU_SRA:  return {1'b0, $unsigned($signed(a) >>> b[4:0])};
            ALU_OR:   return {1'b0, a | b};
            ALU_AND:  return {1'b0, a & b};
            ALU_BEQ:  return {1'b0, 31'd0, a == b};
            ALU_BNE:  return {1'b0, 31'd0, a != b};
            ALU_BLT:  return {1'b0, 31'd0, $signed(a) < $signed(b)};
            ALU_BGE:  return {1'b0, 31'd0, $signed(a) >= $signed(b)};
            ALU_BLTU: return {1'b0, 31'd0, a < b};
            ALU_BGEU: return {1'b0, 31'd0, a >= b};
            default:  return {1'b1, 32'd0};
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {alu_fault, alu_out} <= '0;
        else          {alu_fault, alu_out} <= alu_model(alu_op, alu_a, alu_b);
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {imm, r1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    typedef struct {
        string       name;
        logic [31:0] instr, rs1, rs2, pc;
        logic [4:0]  op;
        logic [31:0] value;
        logic [4:0]  rd;
        logic        wb, taken, fault, chk_tgt;
        logic [31:0] target;
    } vec_t;

    vec_t vecs[13];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input vec_t e, input string tag);
        check({e.name, tag, ".value"}, out_value, e.value);
        check({e.name, tag, ".rd"},    {27'd0, out_rd}, {27'd0, e.rd});
        check({e.name, tag, ".wb_en"}, {31'd0, out_wb_en}, {31'd0, e.wb});
        check({e.name, tag, ".taken"}, {31'd0, out_br_taken}, {31'd0, e.taken});
        check({e.name, tag, ".fault"}, {31'd0, out_fault}, {31'd0, e.fault});
        if (e.chk_tgt) check({e.name, tag, ".target"}, out_br_target, e.target);
    endtask

    // Present one instruction, wait for acceptance, check the registered ALU op.
    task automatic issue(input vec_t v, input bit push);
        int cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check({v.name, ".ready_before_issue"}, {31'd0, in_ready}, 32'd1);
        if (push) exp_q.push_back(v);
        in_instr = v.instr;
        in_rs1   = v.rs1;
        in_rs2   = v.rs2;
        in_pc    = v.pc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({v.name, ".alu_op"}, {27'd0, alu_op}, {27'd0, v.op});
        check({v.name, ".busy"}, {31'd0, in_ready}, 32'd0);
    endtask

    // Wait for the result, compare with the scoreboard head, optionally stall.
    task automatic collect(input int hold);
        vec_t e;
        int cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({e.name, ".latency"}, cyc, 32'd2);
        if (!out_valid) return;
        check_outputs(e, "");
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({e.name, ".stall_valid"}, {31'd0, out_valid}, 32'd1);
            check({e.name, ".stall_ready"}, {31'd0, in_ready}, 32'd0);
            check_outputs(e, ".stall");
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({e.name, ".valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({e.name, ".ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"add",      enc_r(F7_BASE, 5'd2, 5'd1, 3'b000, 5'd5), 32'd7, 32'hFFFF_FFFF, 32'h0,
                     ALU_ADD,  32'd6,          5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{"srai",     enc_i({F7_ALT, 5'd4}, 5'd4, 3'b101, 5'd3, OPC_OP_IMM), 32'h8000_0000, 32'h0, 32'h0,
                     ALU_SRA,  32'hF800_0000,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{"srai_bad", enc_i({7'b0000001, 5'd4}, 5'd4, 3'b101, 5'd3, OPC_OP_IMM), 32'h8000_0000, 32'h0, 32'h0,
                     ALU_SRL,  32'h0800_0000,  5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{"bgeu",     enc_b(13'h1FF8, 5'd2, 5'd1, 3'b111), 32'd3, 32'd3, 32'h100,
                     ALU_BGEU, 32'd1,          5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_00F8};
        vecs[4]  = '{"bltu",     enc_b(13'h1FF8, 5'd2, 5'd1, 3'b110), 32'd3, 32'd3, 32'h100,
                     ALU_BLTU, 32'd0,          5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00F8};
        vecs[5]  = '{"load",     enc_i(12'h004, 5'd1, 3'b010, 5'd6, 7'b0000011), 32'h1234_5678, 32'h9, 32'h40,
                     ALU_ADD,  32'd0,          5'd6,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{"sub_x0",   enc_r(F7_ALT, 5'd2, 5'd1, 3'b000, 5'd0), 32'd5, 32'd7, 32'h0,
                     ALU_SUB,  32'hFFFF_FFFE,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{"br_undef", enc_b(13'h0010, 5'd2, 5'd1, 3'b010), 32'd1, 32'd1, 32'h200,
                     5'b10010, 32'd0,          5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0210};
        vecs[8]  = '{"addi",     enc_i(12'hFFF, 5'd1, 3'b000, 5'd7, OPC_OP_IMM), 32'd0, 32'h0, 32'h0,
                     ALU_ADD,  32'hFFFF_FFFF,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{"slli_bad", enc_i({F7_ALT, 5'd3}, 5'd1, 3'b001, 5'd9, OPC_OP_IMM), 32'd1, 32'h0, 32'h0,
                     ALU_SLL,  32'd8,          5'd9,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{"op_bad",   enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd10), 32'd2, 32'd3, 32'h0,
                     ALU_ADD,  32'd5,          5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{"bne_wrap", enc_b(13'h1FF8, 5'd2, 5'd1, 3'b001), 32'd1, 32'd2, 32'h4,
                     ALU_BNE,  32'd1,          5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC};
        vecs[12] = '{"slti",     enc_i(12'h005, 5'd1, 3'b010, 5'd11, OPC_OP_IMM), 32'hFFFF_FFFD, 32'h0, 32'h0,
                     ALU_SLT,  32'd1,          5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

        // Reset state
        #12;
        check("rst.in_ready",  {31'd0, in_ready},  32'd1);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.alu_op",    {27'd0, alu_op},    32'd0);
        check("rst.alu_a",     alu_a,              32'd0);
        check("rst.out_value", out_value,          32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i], 1'b1);
            collect(0);
        end

        // Backpressure: five stalled RESP cycles
        out_ready = 1'b0;
        issue(vecs[1], 1'b1);
        collect(5);

        // Reset while the ADD is in EXEC; the later ADDI must not see it
        issue(vecs[0], 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst.in_ready",  {31'd0, in_ready},  32'd1);
        check("midrst.alu_op",    {27'd0, alu_op},    32'd0);
        check("midrst.alu_b",     alu_b,              32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst.no_valid", {31'd0, out_valid}, 32'd0);
        end
        reset_n = 1'b1;
        issue(vecs[8], 1'b1);
        collect(0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Issue/collect stage wrapped around the RV32I/E ALU. It accepts one decoded-operand instruction at a time over a valid/ready handshake. It maps OP, OP-IMM and BRANCH instructions onto the ALU's 5-bit op encoding, drives the registered ALU inputs, and waits out the ALU's one-cycle latency. It then presents the writeback value, branch decision, branch target and fault to the downstream writeback/PC stage, holding them until accepted.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  block can accept (high only in IDLE)
- in_instr  in  32  raw instruction word
- in_rs1  in  32  rs1 register value
- in_rs2  in  32  rs2 register value
- in_pc  in  32  instruction address
- alu_op  out  5  to ALU op
- alu_a  out  32  to ALU in_a
- alu_b  out  32  to ALU in_b
- alu_out  in  32  from ALU out
- alu_fault  in  1  from ALU fault
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_rd  out  5  destination register
- out_wb_en  out  1  write out_value to out_rd
- out_value  out  32  ALU result
- out_br_taken  out  1  branch taken
- out_br_target  out  32  in_pc + B-immediate
- out_fault  out  1  illegal instruction (decode or ALU)

## Operation
- FSM states: IDLE, EXEC, CAPT, RESP.
- **IDLE:** in_ready=1. On in_valid, decode and register alu_op/alu_a/alu_b, rd, class, branch target and decode fault. Go to EXEC.
- **EXEC:** ALU samples inputs at this edge. Go to CAPT.
- **CAPT:** latch alu_out into out_value and alu_fault|decode_fault into out_fault. Go to RESP.
- **RESP:** out_valid=1. On out_ready, go to IDLE. Outputs are stable while out_ready=0.
- ALU inputs are held constant from acceptance until return to IDLE.
- Decode rules (opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]):
  - **OP 0110011:** op={0, f7[5], f3}, a=rs1, b=rs2. Decode fault if f7 ∉ {0000000, 0100000}.
  - **OP-IMM 0010011:** a=rs1, b=sign-extended I-imm.
    - f3=101: op={0, f7[5], f3}.
    - Otherwise: op={0, 0, f3}.
    - Decode fault if f3∈{001,101} and f7 ∉ {0000000, 0100000 (f3=101 only)}.
  - **BRANCH 1100011:** op={1, 0, f3}, a=rs1, b=rs2. Undefined f3 (010, 011) is faulted by the ALU.
  - **Any other opcode:** decode fault; op=00000, a=b=0.
- Branch target = in_pc + sign-extended B-immediate, modulo 2^32 (wrap ignored).
- out_br_taken = branch & alu_out[0] & ~out_fault; 0 for non-branches.
- out_wb_en = ~branch & ~out_fault & (rd≠0); out_rd = instr[11:7], or 0 for branches.

## Timing
- Acceptance edge T0. ALU registers at T0+1. Capture at T0+2. out_valid high from T0+2 until the handshake edge.
- Minimum issue interval is 4 cycles: the in_ready rise follows the out handshake edge.
- If out_ready is already high in RESP, the handshake completes on the first RESP edge.
- in_valid while not in IDLE is ignored; upstream must hold the instruction.
- Reset (asynchronous, any state) drives:
  - state=IDLE
  - all outputs 0, except in_ready=1
  - alu_op/alu_a/alu_b = 0
  - any in-flight instruction is discarded, with no out_valid pulse.
- Reset release is sampled on the rising edge. The first acceptance is possible on the first edge with reset_n=1.

## Structure
- Shared package alu_pkg holds:
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_BRANCH)
  - 5-bit ALU op constants (ADD…BGEU)
  - the FSM state enum.
- One natural sub-module: alu_decode (combinational instr→op/operands/decode_fault/target).
- The FSM and registers live in alu_ctrl. The bench instantiates alu_ctrl with the existing ALU.

## Test plan
- ADD x5,x1,x2 with rs1=7, rs2=0xFFFFFFFF, out_ready=1:
  - alu_op=00000 from T0+1
  - out_valid at T0+2, out_value=6, out_rd=5, out_wb_en=1, out_fault=0.
- SRAI x3,x4,4 (f7=0100000) with rs1=0x80000000:
  - alu_op=01101, out_value=0xF8000000.
  - The same instruction with f7=0000001 gives out_fault=1 and out_wb_en=0.
- BGEU, rs1=3, rs2=3, pc=0x100, imm=-8:
  - out_br_taken=1, out_br_target=0x000000F8, out_wb_en=0.
  - The same with BLTU gives out_br_taken=0.
- Opcode 0000011 (load):
  - out_fault=1, out_br_taken=0, out_wb_en=0.
  - Block is in_ready again after the out handshake.
- Backpressure: hold out_ready=0 for 5 cycles in RESP.
  - Outputs stay stable and in_ready=0 throughout.
  - Raising out_ready gives in_ready=1 on the next cycle.
- Assert reset_n=0 during EXEC:
  - Immediately out_valid=0 and in_ready=1.
  - After release, a new ADDI completes normally with no stale result.
